aes_inv_cntx: RTL and testbench

Control FSM for the AES-128 inverse cipher (decryption) path, the counterpart of the encryption round controller.
- Accepts a start request.
- Runs a forward key-expansion phase that fills the round-key store, because decryption consumes round keys last-first.
- Sequences initial AddRoundKey, NR-1 inverse main rounds and the final inverse round.
- Holds done until the consumer acknowledges.
- Drives per-stage enables into the inverse datapath core and key-store addressing.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_inv_cntx_if.sv | 41 ++++
 rtl/aes_inv_rnd_cnt.sv | 48 ++++
 rtl/aes_inv_cntx.sv | 213 +++++++++++++++++++++
 tb/tb_aes_inv_cntx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES control blocks.
//   AES_NR128/192/256 : round counts for the three AES key sizes
//   AES_RW            : default width of round index / key-store address
//   state_e           : inverse-cipher controller states
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR128 = 10;
  localparam int AES_NR192 = 12;
  localparam int AES_NR256 = 14;

  localparam int AES_RW = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEYEXP  = 3'd1,
    INIT_AR = 3'd2,
    MAIN    = 3'd3,
    FINAL   = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/aes_inv_cntx_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cntx_if
// Handshake and datapath-control bundle of the inverse-cipher controller.
//   slave  modport : the controller (takes start/key_new/out_ack, drives rest)
//   master modport : the requester / consumer side
// ---------------------------------------------------------------------------
interface aes_inv_cntx_if
  import aes_pkg::*;
#(
  parameter int RW = AES_RW
) ();

  logic          start;
  logic          key_new;
  logic          out_ack;
  logic          accept;
  logic          busy;
  logic          key_wr_en;
  logic [RW-1:0] key_addr;
  logic [RW-1:0] rndNo;
  logic          enbISR;
  logic          enbISB;
  logic          enbAR;
  logic          enbIMC;
  logic          enbKX;
  logic          done;
  logic [RW-1:0] completed_round;

  modport slave (
    input  start, key_new, out_ack,
    output accept, busy, key_wr_en, key_addr, rndNo,
           enbISR, enbISB, enbAR, enbIMC, enbKX, done, completed_round
  );

  modport master (
    output start, key_new, out_ack,
    input  accept, busy, key_wr_en, key_addr, rndNo,
           enbISR, enbISB, enbAR, enbIMC, enbKX, done, completed_round
  );

endinterface

// File: rtl/aes_inv_rnd_cnt.sv
// ---------------------------------------------------------------------------
// aes_inv_rnd_cnt
// Loadable up/down round counter shared by key expansion (counts up) and
// the inverse rounds (count down).
//   clk, rstn     : clock, asynchronous active-low reset (counter -> 0)
//   load_i/val_i  : load a new value (has priority over up/down)
//   up_i, down_i  : increment / decrement
//   cnt_o         : current count
//   tc_nr_o       : count equals NR
//   tc_one_o      : count equals 1
// ---------------------------------------------------------------------------
module aes_inv_rnd_cnt #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_i,
  input  logic [RW-1:0] load_val_i,
  input  logic          up_i,
  input  logic          down_i,
  output logic [RW-1:0] cnt_o,
  output logic          tc_nr_o,
  output logic          tc_one_o
);

  localparam logic [RW-1:0] NR_V  = RW'(NR);
  localparam logic [RW-1:0] ONE_V = RW'(1);

  logic [RW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)      cnt_d = load_val_i;
    else if (up_i)   cnt_d = cnt_q + ONE_V;
    else if (down_i) cnt_d = cnt_q - ONE_V;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign tc_nr_o  = (cnt_q == NR_V);
  assign tc_one_o = (cnt_q == ONE_V);

endmodule

// File: rtl/aes_inv_cntx.sv
// ---------------------------------------------------------------------------
// aes_inv_cntx
// Control FSM of the AES inverse cipher. A start request first runs the
// forward key expansion (round keys 1..NR written into the key store), then
// the initial AddRoundKey with key NR, NR-1 inverse main rounds reading keys
// NR-1..1, and the final inverse round with key 0. done is held until
// out_ack. Dropping start before DONE aborts back to IDLE.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : aes_inv_cntx_if.slave (start/key_new/out_ack in; accept,
//               busy, stage enables, key-store addressing, done,
//               completed_round out)
// Optional build macro AES_INV_KEYCACHE_EN: remembers that the key store
// holds a complete schedule and, when key_new=0, skips KEYEXP.
// ---------------------------------------------------------------------------
module aes_inv_cntx
  import aes_pkg::*;
#(
  parameter int NR = AES_NR128,
  parameter int RW = AES_RW
) (
  input  logic           clk,
  input  logic           rstn,
  aes_inv_cntx_if.slave  bus
);

  localparam logic [RW-1:0] NR_V    = RW'(NR);
  localparam logic [RW-1:0] NR_M1_V = RW'(NR - 1);
  localparam logic [RW-1:0] ONE_V   = RW'(1);

  state_e        state_q, state_d;
  logic [RW-1:0] cr_q;
  logic          cr_clr, cr_inc;
  logic          cnt_load, cnt_up, cnt_dn;
  logic [RW-1:0] cnt_val, cnt;
  logic          tc_nr, tc_one;
  logic          kc_set, kc_clr, skip_kx;

  aes_inv_rnd_cnt #(.NR(NR), .RW(RW)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .up_i       (cnt_up),
    .down_i     (cnt_dn),
    .cnt_o      (cnt),
    .tc_nr_o    (tc_nr),
    .tc_one_o   (tc_one)
  );

`ifdef AES_INV_KEYCACHE_EN
  logic kc_vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       kc_vld_q <= 1'b0;
    else if (kc_clr) kc_vld_q <= 1'b0;
    else if (kc_set) kc_vld_q <= 1'b1;
  end

  assign skip_kx = kc_vld_q && !bus.key_new;
`else
  logic unused_kc;
  assign unused_kc = kc_set ^ kc_clr ^ bus.key_new;
  assign skip_kx   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // completed_round counts every edge leaving a datapath state, including an
  // abort edge, so a partial operation reports how far it got.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       cr_q <= '0;
    else if (cr_clr) cr_q <= '0;
    else if (cr_inc) cr_q <= cr_q + ONE_V;
  end

  // Next state and counter control
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_up   = 1'b0;
    cnt_dn   = 1'b0;
    cr_clr   = 1'b0;
    cr_inc   = 1'b0;
    kc_set   = 1'b0;
    kc_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cr_clr   = 1'b1;
          cnt_load = 1'b1;
          if (skip_kx) begin
            state_d = INIT_AR;
            cnt_val = NR_V;
          end else begin
            state_d = KEYEXP;
            cnt_val = ONE_V;
          end
        end
      end
      KEYEXP: begin
        if (!bus.start) begin
          state_d = IDLE;
          kc_clr  = 1'b1;   // key store only partially rewritten
        end else if (tc_nr) begin
          state_d = INIT_AR; // counter already sits at NR
          kc_set  = 1'b1;
        end else begin
          cnt_up = 1'b1;
        end
      end
      INIT_AR: begin
        cr_inc = 1'b1;
        if (!bus.start) begin
          state_d = IDLE;
        end else begin
          state_d  = MAIN;
          cnt_load = 1'b1;
          cnt_val  = NR_M1_V;
        end
      end
      MAIN: begin
        cr_inc = 1'b1;
        if (!bus.start) begin
          state_d = IDLE;
        end else if (tc_one) begin
          state_d  = FINAL;
          cnt_load = 1'b1;
          cnt_val  = '0;
        end else begin
          cnt_dn = 1'b1;
        end
      end
      FINAL: begin
        cr_inc = 1'b1;
        if (!bus.start) state_d = IDLE;
        else            state_d = DONE;
      end
      DONE: begin
        if (bus.out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode
  logic          accept, busy, key_wr_en, done;
  logic          enb_isr, enb_isb, enb_ar, enb_imc, enb_kx;
  logic [RW-1:0] key_addr;

  always_comb begin
    accept    = 1'b0;
    busy      = 1'b1;
    key_wr_en = 1'b0;
    key_addr  = '0;
    enb_isr   = 1'b0;
    enb_isb   = 1'b0;
    enb_ar    = 1'b0;
    enb_imc   = 1'b0;
    enb_kx    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = 1'b1;
        busy   = 1'b0;
      end
      KEYEXP: begin
        key_wr_en = 1'b1;
        enb_kx    = 1'b1;
        key_addr  = cnt;
      end
      INIT_AR: begin
        enb_ar   = 1'b1;
        key_addr = NR_V;
      end
      MAIN: begin
        enb_isr  = 1'b1;
        enb_isb  = 1'b1;
        enb_ar   = 1'b1;
        enb_imc  = 1'b1;
        key_addr = cnt;
      end
      FINAL: begin
        enb_isr = 1'b1;
        enb_isb = 1'b1;
        enb_ar  = 1'b1;
      end
      DONE: done = 1'b1;
      default: begin
        accept = 1'b0;
        busy   = 1'b1;
      end
    endcase
  end

  assign bus.accept          = accept;
  assign bus.busy            = busy;
  assign bus.key_wr_en       = key_wr_en;
  assign bus.key_addr        = key_addr;
  assign bus.rndNo           = key_addr;
  assign bus.enbISR          = enb_isr;
  assign bus.enbISB          = enb_isb;
  assign bus.enbAR           = enb_ar;
  assign bus.enbIMC          = enb_imc;
  assign bus.enbKX           = enb_kx;
  assign bus.done            = done;
  assign bus.completed_round = cr_q;

endmodule

// File: tb/tb_aes_inv_cntx.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cntx
// Self-checking bench for aes_inv_cntx (NR=10, RW=4). A timeline model
// (cycles since accept, length of the key phase) predicts every output
// after every clock; directed tables and sequences cover the nominal run,
// abort, done hold, reset mid-KEYEXP, back-to-back and the key cache.
// ---------------------------------------------------------------------------
module tb_aes_inv_cntx;

  localparam int NR = 10;
  localparam int RW = 4;
`ifdef AES_INV_KEYCACHE_EN
  localparam bit KC = 1'b1;
`else
  localparam bit KC = 1'b0;
`endif

  typedef struct packed {
    logic       accept;
    logic       busy;
    logic       kwr;
    logic [3:0] addr;
    logic [3:0] rnd;
    logic       isr;
    logic       isb;
    logic       ar;
    logic       imc;
    logic       kx;
    logic       done;
    logic [3:0] cr;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  aes_inv_cntx_if #(.RW(RW)) bus ();

  aes_inv_cntx #(.NR(NR), .RW(RW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Timeline model: m_k = cycles since accept (0 = idle), m_ke = length of
  // the key-expansion phase of the current operation (NR or 0 when cached).
  int m_k    = 0;
  int m_ke   = NR;
  int m_cr   = 0;
  bit m_flag = 1'b0;

  function automatic out_t mk(bit acc, bit bsy, bit kwr, int addr, bit isr,
                              bit isb, bit ar, bit imc, bit kx, bit dn, int cr);
    out_t o;
    o.accept = acc; o.busy = bsy; o.kwr = kwr;
    o.addr = 4'(addr); o.rnd = 4'(addr);
    o.isr = isr; o.isb = isb; o.ar = ar; o.imc = imc; o.kx = kx;
    o.done = dn; o.cr = 4'(cr);
    return o;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.accept = bus.accept; o.busy = bus.busy; o.kwr = bus.key_wr_en;
    o.addr = bus.key_addr; o.rnd = bus.rndNo;
    o.isr = bus.enbISR; o.isb = bus.enbISB; o.ar = bus.enbAR;
    o.imc = bus.enbIMC; o.kx = bus.enbKX; o.done = bus.done;
    o.cr = bus.completed_round;
    return o;
  endfunction

  function automatic out_t model_out();
    int dp;
    if (m_k == 0) return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_cr);
    if (m_k <= m_ke) return mk(0, 1, 1, m_k, 0, 0, 0, 0, 1, 0, m_cr);
    dp = m_k - m_ke;  // 1: initial AR, 2..NR: main, NR+1: final, beyond: done
    if (dp == 1)       return mk(0, 1, 0, NR, 0, 0, 1, 0, 0, 0, m_cr);
    if (dp <= NR)      return mk(0, 1, 0, NR - dp + 1, 1, 1, 1, 1, 0, 0, m_cr);
    if (dp == NR + 1)  return mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, m_cr);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, m_cr);
  endfunction

  function automatic void model_update(bit s, bit kn, bit ack);
    if (m_k == 0) begin
      if (s) begin
        m_ke = (KC && m_flag && !kn) ? 0 : NR;
        m_k  = 1;
        m_cr = 0;
      end
    end else if (m_k - m_ke >= NR + 2) begin
      if (ack) m_k = 0;
    end else begin
      if (m_k > m_ke) m_cr = m_cr + 1;
      if (!s) begin
        if (m_k <= m_ke) m_flag = 1'b0;
        m_k = 0;
      end else begin
        if (m_k == m_ke) m_flag = 1'b1;
        m_k = m_k + 1;
      end
    end
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // One clock: drive, clock, update model, compare 1 time unit later.
  task automatic step(input bit s, input bit kn, input bit ack, input string name);
    bus.start   = s;
    bus.key_new = kn;
    bus.out_ack = ack;
    @(posedge clk);
    model_update(s, kn, ack);
    #1;
    check(name, dut_out(), model_out());
  endtask

  task automatic do_reset(input string name);
    rstn = 1'b0;
    m_k = 0; m_cr = 0; m_flag = 1'b0; m_ke = NR;
    #1;
    check(name, dut_out(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    bus.start = 1'b0; bus.key_new = 1'b0; bus.out_ack = 1'b0;
    rstn = 1'b0;

    tbl[0] = '{1,  mk(0, 1, 1, 1,  0, 0, 0, 0, 1, 0, 0)};
    tbl[1] = '{4,  mk(0, 1, 1, 4,  0, 0, 0, 0, 1, 0, 0)};
    tbl[2] = '{10, mk(0, 1, 1, 10, 0, 0, 0, 0, 1, 0, 0)};
    tbl[3] = '{11, mk(0, 1, 0, 10, 0, 0, 1, 0, 0, 0, 0)};
    tbl[4] = '{12, mk(0, 1, 0, 9,  1, 1, 1, 1, 0, 0, 1)};
    tbl[5] = '{20, mk(0, 1, 0, 1,  1, 1, 1, 1, 0, 0, 9)};
    tbl[6] = '{21, mk(0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 10)};
    tbl[7] = '{22, mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 11)};
    tbl[8] = '{24, mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 11)};

    repeat (2) @(posedge clk);
    do_reset("reset");

    // Nominal run; ack pulsed 3 cycles after done rises, start held.
    for (int c = 1; c <= 24; c++) begin
      step(1, 0, 0, "nominal");
      for (int i = 0; i < 9; i++)
        if (tbl[i].cyc == c) check("nominal_tbl", dut_out(), tbl[i].exp);
    end
    step(1, 0, 1, "nominal_ack");
    check("ack_to_idle", dut_out(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11));
    $display("op nominal: done at T+22, completed_round=%0d", bus.completed_round);

    // Back-to-back: start still high, one IDLE cycle then KEYEXP.
    step(1, 0, 0, "b2b_start");
    check("b2b_keyexp", dut_out(), mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0));

    // Abort in MAIN at rndNo=5.
    for (int c = 2; c <= 16; c++) step(1, 0, 0, "abort_run");
    check_int("abort_rnd5", int'(bus.rndNo), 5);
    step(0, 0, 0, "abort_edge");
    check("abort_idle", dut_out(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    for (int c = 0; c < 3; c++) step(0, 0, 1, "abort_idle_hold");
    $display("op abort: completed_round=%0d", bus.completed_round);

    // Done hold for 50 cycles with start toggling.
    for (int c = 1; c <= 22; c++) step(1, 0, 0, "hold_run");
    for (int c = 0; c < 50; c++) begin
      step(1'($urandom_range(0, 1)), 0, 0, "hold_done");
      check_int("hold_done_bit", int'(bus.done), 1);
    end
    step(0, 0, 1, "hold_ack");
    $display("op hold: released by out_ack");

    // Reset in KEYEXP at key_addr=4, then restart from key_addr=1.
    for (int c = 1; c <= 4; c++) step(1, 0, 0, "rst_run");
    check_int("rst_addr4", int'(bus.key_addr), 4);
    do_reset("rst_async");
    step(1, 0, 0, "rst_restart");
    check_int("rst_restart_addr", int'(bus.key_addr), 1);
    step(0, 0, 0, "rst_abort");
    $display("op reset mid-keyexp: restarted at key_addr=1");

`ifdef AES_INV_KEYCACHE_EN
    // Key cache: full run, then cached run (done at T+12), then key_new=1.
    for (int c = 1; c <= 22; c++) step(1, 0, 0, "kc_first");
    step(0, 0, 1, "kc_first_ack");
    for (int c = 1; c <= 12; c++) begin
      step(1, 0, 0, "kc_cached");
      check_int("kc_cached_done", int'(bus.done), (c >= 12) ? 1 : 0);
    end
    step(0, 0, 1, "kc_cached_ack");
    for (int c = 1; c <= 22; c++) begin
      step(1, 1, 0, "kc_newkey");
      check_int("kc_newkey_done", int'(bus.done), (c >= 22) ? 1 : 0);
    end
    step(0, 0, 1, "kc_newkey_ack");
    $display("op keycache: cached done at T+12, new key done at T+22");
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 99) < 96), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 99) < 25), "random");
    end
    $display("random phase: 3000 cycles");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
